// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types and round-robin pick for the RAM port arbiter
package ram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Rotating priority: ptr+1 is searched first, ptr itself last.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [PTR_W-1:0]   ptr,
                                                 input logic [MAX_REQ-1:0] valid,
                                                 input int                 n);
    logic [MAX_REQ-1:0] pick;
    logic [3:0]         idx;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if (k <= n && pick == '0 && valid[idx[PTR_W-1:0]]) pick[idx[PTR_W-1:0]] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side request/response bundle
interface ram_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int WIDTHAD = 16,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_we;
  logic [NUM_REQ-1:0]         req_lock;
  logic [NUM_REQ*WIDTHAD-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [WIDTH-1:0]           rsp_data;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// rtl/ram_port_arbiter_rr_arbiter.sv - one-hot round-robin pick with its pointer register
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    pick                     = rr_pick(PTR_W'(rr_ptr), valid_ext, NUM_REQ);
    grant                    = NUM_REQ'(pick);
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one block-RAM port among NUM_REQ requesters
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int WIDTHAD  = 16,
  parameter int WIDTH    = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_port_arbiter_if.slave  bus,
  output logic [WIDTHAD-1:0] ram_address,
  output logic               ram_wren,
  output logic [WIDTH-1:0]   ram_data,
  output logic               ram_rden,
  input  logic [WIDTH-1:0]   ram_q
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   g;
  logic [NUM_REQ-1:0] rsp_q;

  // While locked only the owner may compete; nothing competes during reset.
  always_comb begin
    elig = '0;
    if (rst_n) begin
      if (state == LOCKED) elig[owner] = bus.req_valid[owner];
      else                 elig        = bus.req_valid;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (elig),
    .grant     (grant),
    .grant_idx (g)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ARB: begin
        if (|grant && bus.req_lock[g] && MAX_LOCK > 1) begin
          state_nxt    = LOCKED;
          owner_nxt    = g;
          lock_cnt_nxt = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (!bus.req_valid[owner] || !bus.req_lock[owner] ||
            lock_cnt >= CNT_W'(MAX_LOCK - 1)) begin
          state_nxt    = ARB;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    ram_rden    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ram_address = bus.req_addr[i*WIDTHAD +: WIDTHAD];
        ram_data    = bus.req_wdata[i*WIDTH +: WIDTH];
        ram_wren    = bus.req_we[i];
        ram_rden    = ~bus.req_we[i];
      end
    end
    bus.req_ready = grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rsp_q <= '0;
    else        rsp_q <= grant & ~bus.req_we;
  end

  // Gating with rst_n drops a response whose read was granted just before reset.
  assign bus.rsp_valid = rsp_q & {NUM_REQ{rst_n}};
  assign bus.rsp_data  = ram_q;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one port of the dual-port block RAM (1-cycle registered-address read, unregistered q) between NUM_REQ requesters, e.g. fetch, load/store and debug. Round-robin arbitration with an optional per-requester lock for multi-beat bursts. Returns read data to the winning requester with a one-cycle response pulse. Sits between the core's memory clients and one RAM port (address/wren/data/rden/q).

Parameters:
NUM_REQ, 3, number of requesters (2..8)
WIDTHAD, 16, RAM address width
WIDTH, 32, RAM data width
MAX_LOCK, 16, max consecutive grants held by a locked requester before forced release

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
req_we  in  NUM_REQ  1=write, 0=read
req_lock  in  NUM_REQ  hold grant after this beat
req_addr  in  NUM_REQ*WIDTHAD  flattened, requester i at [i*WIDTHAD +: WIDTHAD]
req_wdata  in  NUM_REQ*WIDTH  flattened, same packing
rsp_valid  out  NUM_REQ  one-cycle pulse, read data for requester i on rsp_data
rsp_data  out  WIDTH  read data (= ram_q)
ram_address  out  WIDTHAD  to RAM port
ram_wren  out  1  to RAM port
ram_data  out  WIDTH  to RAM port
ram_rden  out  1  to RAM port
ram_q  in  WIDTH  from RAM port

Behaviour:
- Clock is clk; reset is synchronous, active-low (rst_n). On reset: rr_ptr=0, state=ARB, lock_cnt=0, rsp_valid=0. req_ready=0 during reset.
- Grant is combinational in the same cycle: at most one req_ready bit is set, and only for a requester with req_valid=1. No requests means req_ready=0, ram_wren=0, ram_rden=0.
- RAM drive: ram_address, ram_data and ram_wren=req_we[g] come from granted requester g. ram_rden=~req_we[g]. All are 0 when nothing is granted.
- Read latency exactly 1: read granted in cycle T gives rsp_valid[g]=1 in T+1, with rsp_data=ram_q. rsp_data is don't-care when rsp_valid=0. Writes produce no response.
- Back-to-back reads from different requesters on consecutive cycles are legal; responses arrive in order.
- State ARB: round-robin. Search starts at rr_ptr+1 mod NUM_REQ; the first valid requester wins. On a grant to g: rr_ptr<=g. If req_lock[g]=1, go to LOCKED(owner=g) with lock_cnt<=1.
- State LOCKED: only the owner can be granted; others see req_ready=0. On each owner beat, lock_cnt increments.
- Return LOCKED->ARB when any of these holds:
  - owner beat with req_lock=0;
  - owner req_valid=0 for one cycle (lock abandoned, no grant that cycle);
  - lock_cnt reaches MAX_LOCK on a beat (that beat completes; the next cycle is ARB with the owner lowest priority).
- Reset mid-operation: rsp_valid for a read granted in the reset cycle or the cycle before is suppressed. No RAM access is issued during reset.
- Simultaneous requests: exactly one grant. Across NUM_REQ consecutive contended unlocked cycles, each continuously-valid requester is granted exactly once.
- Requesters must hold addr/wdata/we/lock stable while valid&~ready (checked by assertion in bench).

Decomposition:
- Shared package ram_arb_pkg: state enum {ARB, LOCKED}, and the rr_pick function (rotate-priority one-hot select given ptr and valid vector).
- One sub-module, rr_arbiter: combinational one-hot pick from a valid vector plus the rr_ptr register. Lock FSM, response pipeline and RAM muxing stay in ram_port_arbiter.

Test Plan:
- Single read: ram_port_arbiter behavioural RAM preloaded addr 0x0010=0xDEADBEEF; req0 reads 0x0010 -> req_ready=001 in T, rsp_valid=001 with rsp_data=0xDEADBEEF in T+1.
- Contention: all 3 valid continuously for 6 cycles, reads, from reset -> grants 1,2,0,1,2,0 (one-hot 010,100,001,...). rsp_valid follows each one cycle later.
- Write then read: req2 writes 0x0004=0x12345678; req1 reads 0x0004 the next cycle -> rsp_valid=010, rsp_data=0x12345678.
- Lock burst: req0 locks 4 beats while req1 is valid -> req1 is blocked 4 cycles and granted in cycle 5. With MAX_LOCK=2 and lock held, req1 is granted after beat 2.
- Abandoned lock: req0 locks, then drops valid for one cycle -> FSM returns to ARB and req2 is granted the next cycle.
- Reset mid-read: read granted in T, rst_n=0 in T+1 -> rsp_valid stays 0, and no ram_rden/ram_wren while reset is low.
